uart_scale_cfg_parser: RTL and testbench
========================================

# uart_scale_cfg_parser

Parses the byte stream from the host UART receiver into a scaling configuration (source and destination frame sizes) for the bilinear interpolation core. Frames are checked, validated and acknowledged. The parser holds the accepted setting as pending and commits it to the active outputs only on a frame-start strobe, so the scaler never changes geometry mid-frame. The block sits between the UART RX/TX byte engines and the interpolation core's configuration inputs.

## Interface
- `TIMEOUT_CYC`, 96000: maximum idle cycles between bytes of one packet (1 ms at 96 MHz).
- `MAX_W`, 2560: largest legal width, source or destination.
- `MAX_H`, 1440: largest legal height, source or destination.
- `DEF_SRC_W` / `DEF_SRC_H`, 1920 / 1080: source size after reset.
- `DEF_DST_W` / `DEF_DST_H`, 2560 / 1440: destination size after reset.

Ports (single clock domain):
- `sys_clk_96M`  in  1: the only clock.
- `sys_rst`  in  1: synchronous, active-high reset.
- `rx_data_i`  in  8: received byte.
- `rx_valid_i`  in  1: one-cycle strobe, `rx_data_i` valid.
- `tx_data_o`  out  8: reply byte.
- `tx_valid_o`  out  1: reply byte request, held until accepted.
- `tx_ready_i`  in  1: the TX engine accepts the byte when `tx_valid_o` and `tx_ready_i` are both high.
- `frame_start_i`  in  1: one-cycle strobe at the start of an input frame (vsync edge, already synchronised).
- `src_w_o`, `src_h_o`, `dst_w_o`, `dst_h_o`  out  12 each: active configuration.
- `cfg_update_o`  out  1: one-cycle pulse in the cycle the active configuration changes.
- `pkt_err_o`  out  1: one-cycle pulse on any rejected or timed-out packet.

## Operation
- **Packet format:** `0xA5 0x5A CMD P0..P7 CHK`, 12 bytes in total.
  - Payload: `src_w`, `src_h`, `dst_w`, `dst_h`, each 16-bit big-endian.
  - `CHK` = (CMD + P0 + … + P7) mod 256.
- **Only CMD `0x01` is legal.**
- **State machine:**
  - `IDLE`: `0xA5` → `HDR2`; any other byte is ignored.
  - `HDR2`: `0x5A` → `CMD`; `0xA5` stays in `HDR2`; any other byte → `IDLE`. A header mismatch produces no error pulse.
  - `CMD`: byte stored, → `PAY`.
  - `PAY`: 8 bytes counted by a 3-bit counter, → `CHK`.
  - `CHK`: byte stored, → `EVAL`.
  - `EVAL`: one cycle, → `REPLY`.
  - `REPLY`: waits for the TX handshake, then → `IDLE`.
- **Checksum:** an 8-bit running sum accumulates CMD and the payload bytes.
- **Validation in `EVAL`:** the packet is good if all of the following hold:
  - CMD == `0x01`;
  - the checksum matches;
  - every dimension is nonzero;
  - each width ≤ `MAX_W`, each height ≤ `MAX_H`;
  - bits [15:12] of every dimension are zero.
- **Good packet:** load the pending registers, set `pending_flag`, reply `0x06` (ACK).
- **Bad packet:** pending registers unchanged, pulse `pkt_err_o`, reply `0x15` (NAK).
- **Timeout:** in `HDR2`, `CMD`, `PAY` or `CHK`, an idle count reaching `TIMEOUT_CYC` with no `rx_valid_i` → `IDLE`, pulse `pkt_err_o`, no reply. The idle counter clears on every `rx_valid_i`.
- **Bytes arriving in `EVAL` or `REPLY`** are dropped.
- **Commit:** when `frame_start_i` is high and `pending_flag` is set, copy pending to active, pulse `cfg_update_o` and clear `pending_flag`.
  - A new good packet overwrites a still-pending setting; the last one wins.
  - If `frame_start_i` and the `EVAL` write land in the same cycle, commit the old pending value (if any). The new value stays pending for the next frame.

## Timing
- **Reset values:**
  - Active and pending registers = `DEF_*`; `pending_flag` = 0.
  - `tx_valid_o` = 0, `tx_data_o` = `0x00`, `cfg_update_o` = 0, `pkt_err_o` = 0.
  - State = `IDLE`, idle counter = 0.
- **Reset mid-packet or mid-reply:** the packet is discarded and `tx_valid_o` drops the next cycle.
- **Reply latency:** `tx_valid_o` rises the cycle after `EVAL`, which is two cycles after the `CHK` byte strobe. `pkt_err_o` pulses in the `EVAL` cycle.
- **TX handshake:** `tx_data_o` stays stable while `tx_valid_o` is high. On handshake, `tx_valid_o` falls next cycle and the state returns to `IDLE`.
- **Commit latency:** active outputs and `cfg_update_o` are registered and change in the cycle after the qualifying `frame_start_i`.
- **All outputs are registered.**

## Structure
- **Shared package `scale_cfg_pkg`:**
  - header constants `0xA5` / `0x5A`;
  - `CMD_SET_SCALE` = `0x01`;
  - `ACK` = `0x06`, `NAK` = `0x15`;
  - state enum;
  - a 12-bit dimension typedef shared with the interpolation core.
- **Sub-module:** a single `cfg_shadow_reg` holding the pending/active register pair and the commit logic. The parser FSM stays in the top level.

## Test plan
- **Valid packet:** `A5 5A 01 05 00 02 D0 0A 00 05 A0 CHK` (1280×720 → 2560×1440). Expect ACK `0x06`, no output change until `frame_start_i`; one cycle after it, outputs read 1280/720/2560/1440 with one `cfg_update_o` pulse.
- **Checksum off by one:** expect NAK `0x15`, one `pkt_err_o` pulse, outputs unchanged; a later `frame_start_i` produces no `cfg_update_o`.
- **Invalid dimensions:** `dst_w` = 2561 expects NAK; `src_h` = 0 expects NAK; CMD `0x02` with a correct checksum expects NAK.
- **Byte gap:** stop after 5 bytes for `TIMEOUT_CYC` cycles. Expect a `pkt_err_o` pulse, no TX, and the next full good packet is ACKed.
- **Two good packets before a frame start:** only the second is applied. Also drive `frame_start_i` in the `EVAL` cycle: the old pending value is committed and the new one applies on the following frame.
- **Back-pressure and reset:** hold `tx_ready_i` low for 50 cycles; `tx_valid_o` and `tx_data_o` must stay stable. Then assert `sys_rst` mid-payload: `tx_valid_o` = 0 and outputs return to 1920/1080/2560/1440.

Source files
------------

// File: rtl/scale_cfg_pkg.sv
// Shared definitions for the UART scaling-configuration path and the interpolation core:
// framing bytes, reply codes, parser states and the 12-bit dimension type.
package scale_cfg_pkg;

    localparam logic [7:0] HDR_BYTE_1    = 8'hA5;
    localparam logic [7:0] HDR_BYTE_2    = 8'h5A;
    localparam logic [7:0] CMD_SET_SCALE = 8'h01;
    localparam logic [7:0] ACK           = 8'h06;
    localparam logic [7:0] NAK           = 8'h15;

    typedef logic [11:0] dim_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR2  = 3'd1,
        ST_CMD   = 3'd2,
        ST_PAY   = 3'd3,
        ST_CHK   = 3'd4,
        ST_EVAL  = 3'd5,
        ST_REPLY = 3'd6
    } parse_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

    // The upper nibble check matters for the core: only 12 bits are forwarded.
    function automatic logic dim_legal(input logic [15:0] dim, input logic [15:0] max_dim);
        return (dim != 16'd0) && (dim[15:12] == 4'd0) && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Pending/active configuration pair; the pending set is copied to the active
// outputs only on a frame-start strobe so geometry never changes mid-frame.
module cfg_shadow_reg
    import scale_cfg_pkg::*;
#(
    parameter dim_t DEF_SRC_W = 12'd1920,
    parameter dim_t DEF_SRC_H = 12'd1080,
    parameter dim_t DEF_DST_W = 12'd2560,
    parameter dim_t DEF_DST_H = 12'd1440
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  dim_t load_src_w,
    input  dim_t load_src_h,
    input  dim_t load_dst_w,
    input  dim_t load_dst_h,
    input  logic frame_start,
    output dim_t src_w,
    output dim_t src_h,
    output dim_t dst_w,
    output dim_t dst_h,
    output logic cfg_update
);

    dim_t pend_src_w_r;
    dim_t pend_src_h_r;
    dim_t pend_dst_w_r;
    dim_t pend_dst_h_r;
    logic pend_flag_r;
    logic commit_s;

    assign commit_s = frame_start && pend_flag_r;

    // Commit uses the pending value from before this edge, so a same-cycle load waits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_w        <= DEF_SRC_W;
            src_h        <= DEF_SRC_H;
            dst_w        <= DEF_DST_W;
            dst_h        <= DEF_DST_H;
            pend_src_w_r <= DEF_SRC_W;
            pend_src_h_r <= DEF_SRC_H;
            pend_dst_w_r <= DEF_DST_W;
            pend_dst_h_r <= DEF_DST_H;
            pend_flag_r  <= 1'b0;
            cfg_update   <= 1'b0;
        end else begin
            cfg_update <= commit_s;
            if (commit_s) begin
                src_w <= pend_src_w_r;
                src_h <= pend_src_h_r;
                dst_w <= pend_dst_w_r;
                dst_h <= pend_dst_h_r;
            end
            if (load) begin
                pend_src_w_r <= load_src_w;
                pend_src_h_r <= load_src_h;
                pend_dst_w_r <= load_dst_w;
                pend_dst_h_r <= load_dst_h;
                pend_flag_r  <= 1'b1;
            end else if (commit_s) begin
                pend_flag_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_scale_cfg_parser.sv
// Parses A5 5A CMD P0..P7 CHK packets from the UART receiver into a scaling
// configuration, replies ACK/NAK and hands good settings to the shadow register.
module uart_scale_cfg_parser
    import scale_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32'd96000,
    parameter logic [15:0] MAX_W       = 16'd2560,
    parameter logic [15:0] MAX_H       = 16'd1440,
    parameter dim_t        DEF_SRC_W   = 12'd1920,
    parameter dim_t        DEF_SRC_H   = 12'd1080,
    parameter dim_t        DEF_DST_W   = 12'd2560,
    parameter dim_t        DEF_DST_H   = 12'd1440
) (
    input  logic        sys_clk_96M,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic        frame_start_i,
    output logic [11:0] src_w_o,
    output logic [11:0] src_h_o,
    output logic [11:0] dst_w_o,
    output logic [11:0] dst_h_o,
    output logic        cfg_update_o,
    output logic        pkt_err_o
);

    localparam int unsigned    TW        = $clog2(TIMEOUT_CYC + 32'd1);
    localparam logic [TW-1:0]  IDLE_LAST = TW'(TIMEOUT_CYC - 32'd1);

    parse_state_t  state_r;
    logic [TW-1:0] idle_cnt_r;
    logic [7:0]    cmd_r;
    logic [7:0]    sum_r;
    logic [7:0]    pay_r [8];
    logic [2:0]    pay_cnt_r;
    logic          good_r;
    logic          waiting_s;
    logic          timeout_s;
    logic          good_s;
    logic          load_s;
    logic [15:0]   src_w_s;
    logic [15:0]   src_h_s;
    logic [15:0]   dst_w_s;
    logic [15:0]   dst_h_s;

    assign src_w_s = {pay_r[0], pay_r[1]};
    assign src_h_s = {pay_r[2], pay_r[3]};
    assign dst_w_s = {pay_r[4], pay_r[5]};
    assign dst_h_s = {pay_r[6], pay_r[7]};

    assign waiting_s = (state_r == ST_HDR2) || (state_r == ST_CMD) ||
                       (state_r == ST_PAY)  || (state_r == ST_CHK);
    assign timeout_s = waiting_s && !rx_valid_i && (idle_cnt_r == IDLE_LAST);

    // Verdict is taken as the checksum byte arrives so the error pulse lands in EVAL.
    assign good_s = (cmd_r == CMD_SET_SCALE) && (sum_r == rx_data_i) &&
                    dim_legal(src_w_s, MAX_W) && dim_legal(src_h_s, MAX_H) &&
                    dim_legal(dst_w_s, MAX_W) && dim_legal(dst_h_s, MAX_H);
    assign load_s = (state_r == ST_EVAL) && good_r;

    // Packet framing, inter-byte timeout, validation verdict and reply handshake.
    always_ff @(posedge sys_clk_96M) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            idle_cnt_r <= {TW{1'b0}};
            cmd_r      <= 8'h00;
            sum_r      <= 8'h00;
            pay_cnt_r  <= 3'd0;
            good_r     <= 1'b0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            pkt_err_o  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                pay_r[i] <= 8'h00;
            end
        end else begin
            pkt_err_o <= 1'b0;
            if (waiting_s && !rx_valid_i) begin
                idle_cnt_r <= idle_cnt_r + TW'(1'b1);
            end else begin
                idle_cnt_r <= {TW{1'b0}};
            end
            if (timeout_s) begin
                state_r   <= ST_IDLE;
                pkt_err_o <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rx_valid_i && (rx_data_i == HDR_BYTE_1)) begin
                            state_r <= ST_HDR2;
                        end
                    end
                    ST_HDR2: begin
                        if (rx_valid_i) begin
                            if (rx_data_i == HDR_BYTE_2) begin
                                state_r <= ST_CMD;
                            end else if (rx_data_i != HDR_BYTE_1) begin
                                state_r <= ST_IDLE;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid_i) begin
                            cmd_r     <= rx_data_i;
                            sum_r     <= rx_data_i;
                            pay_cnt_r <= 3'd0;
                            state_r   <= ST_PAY;
                        end
                    end
                    ST_PAY: begin
                        if (rx_valid_i) begin
                            pay_r[pay_cnt_r] <= rx_data_i;
                            sum_r            <= csum_add(sum_r, rx_data_i);
                            pay_cnt_r        <= pay_cnt_r + 3'd1;
                            if (pay_cnt_r == 3'd7) begin
                                state_r <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (rx_valid_i) begin
                            good_r    <= good_s;
                            pkt_err_o <= !good_s;
                            state_r   <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        tx_data_o  <= good_r ? ACK : NAK;
                        tx_valid_o <= 1'b1;
                        state_r    <= ST_REPLY;
                    end
                    ST_REPLY: begin
                        if (tx_ready_i) begin
                            tx_valid_o <= 1'b0;
                            state_r    <= ST_IDLE;
                        end
                    end
                    default: begin
                        tx_valid_o <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    cfg_shadow_reg #(
        .DEF_SRC_W (DEF_SRC_W),
        .DEF_SRC_H (DEF_SRC_H),
        .DEF_DST_W (DEF_DST_W),
        .DEF_DST_H (DEF_DST_H)
    ) u_shadow (
        .clk         (sys_clk_96M),
        .rst         (sys_rst),
        .load        (load_s),
        .load_src_w  (src_w_s[11:0]),
        .load_src_h  (src_h_s[11:0]),
        .load_dst_w  (dst_w_s[11:0]),
        .load_dst_h  (dst_h_s[11:0]),
        .frame_start (frame_start_i),
        .src_w       (src_w_o),
        .src_h       (src_h_o),
        .dst_w       (dst_w_o),
        .dst_h       (dst_h_o),
        .cfg_update  (cfg_update_o)
    );

endmodule

// File: tb/tb_uart_scale_cfg_parser.sv
// Directed and randomized bench for uart_scale_cfg_parser against a packet-level
// reference model (pending/active arrays, arithmetic validity rules).
module tb_uart_scale_cfg_parser;

    localparam int T_CYC = 200;
    localparam int MAX_W = 2560;
    localparam int MAX_H = 1440;

    logic        sys_clk_96M = 1'b0;
    logic        sys_rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        frame_start_i;
    logic [11:0] src_w_o;
    logic [11:0] src_h_o;
    logic [11:0] dst_w_o;
    logic [11:0] dst_h_o;
    logic        cfg_update_o;
    logic        pkt_err_o;

    int n_pass  = 0;
    int n_total = 0;

    int act [4];
    int pend [4];
    bit pflag;
    logic [7:0] pkt_q [$];

    uart_scale_cfg_parser #(.TIMEOUT_CYC(T_CYC)) dut (
        .sys_clk_96M   (sys_clk_96M),
        .sys_rst       (sys_rst),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .frame_start_i (frame_start_i),
        .src_w_o       (src_w_o),
        .src_h_o       (src_h_o),
        .dst_w_o       (dst_w_o),
        .dst_h_o       (dst_h_o),
        .cfg_update_o  (cfg_update_o),
        .pkt_err_o     (pkt_err_o)
    );

    always #5 sys_clk_96M = ~sys_clk_96M;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_src_w"}, {20'd0, src_w_o}, act[0]);
        check({tag, "_src_h"}, {20'd0, src_h_o}, act[1]);
        check({tag, "_dst_w"}, {20'd0, dst_w_o}, act[2]);
        check({tag, "_dst_h"}, {20'd0, dst_h_o}, act[3]);
    endtask

    task automatic model_reset();
        act   = '{1920, 1080, 2560, 1440};
        pend  = act;
        pflag = 1'b0;
    endtask

    function automatic bit model_good(input int cmd, input int d0, input int d1,
                                      input int d2, input int d3, input int delta);
        return (cmd == 1) && (delta == 0) &&
               (d0 >= 1) && (d0 <= MAX_W) && (d1 >= 1) && (d1 <= MAX_H) &&
               (d2 >= 1) && (d2 <= MAX_W) && (d3 >= 1) && (d3 <= MAX_H);
    endfunction

    task automatic build_pkt(input int cmd, input int d0, input int d1, input int d2,
                             input int d3, input int delta);
        int d [4];
        int s;
        d = '{d0, d1, d2, d3};
        pkt_q = {};
        pkt_q.push_back(8'hA5);
        pkt_q.push_back(8'h5A);
        pkt_q.push_back(8'(cmd));
        s = cmd;
        foreach (d[i]) begin
            pkt_q.push_back(8'((d[i] >> 8) & 255));
            pkt_q.push_back(8'(d[i] & 255));
            s = s + ((d[i] >> 8) & 255) + (d[i] & 255);
        end
        pkt_q.push_back(8'((s + delta) % 256));
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge sys_clk_96M);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input int cmd, input int d0, input int d1, input int d2,
                            input int d3, input int delta, input bit fs_eval, input bit gaps);
        bit good;
        bit old_flag;
        good = model_good(cmd, d0, d1, d2, d3, delta);
        build_pkt(cmd, d0, d1, d2, d3, delta);
        foreach (pkt_q[i]) begin
            if (gaps && (i > 0)) repeat ($urandom_range(0, 3)) @(negedge sys_clk_96M);
            send_byte(pkt_q[i]);
        end
        check("eval_pkt_err", {31'd0, pkt_err_o}, {31'd0, !good});
        check("eval_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        old_flag = pflag;
        if (fs_eval) frame_start_i = 1'b1;
        @(negedge sys_clk_96M);
        frame_start_i = 1'b0;
        check("reply_tx_valid", {31'd0, tx_valid_o}, 32'd1);
        check("reply_tx_data", {24'd0, tx_data_o}, good ? 32'h06 : 32'h15);
        check("reply_pkt_err_low", {31'd0, pkt_err_o}, 32'd0);
        check("reply_cfg_update", {31'd0, cfg_update_o}, {31'd0, fs_eval && old_flag});
        if (fs_eval && pflag) begin
            act   = pend;
            pflag = 1'b0;
        end
        if (good) begin
            pend  = '{d0, d1, d2, d3};
            pflag = 1'b1;
        end
        check_outputs("reply");
        if (tx_ready_i) begin
            @(negedge sys_clk_96M);
            check("reply_done_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        end
    endtask

    task automatic frame_pulse();
        bit exp_upd;
        exp_upd = pflag;
        frame_start_i = 1'b1;
        @(negedge sys_clk_96M);
        frame_start_i = 1'b0;
        if (pflag) begin
            act   = pend;
            pflag = 1'b0;
        end
        check("frame_cfg_update", {31'd0, cfg_update_o}, {31'd0, exp_upd});
        check_outputs("frame");
        @(negedge sys_clk_96M);
        check("frame_update_pulse_end", {31'd0, cfg_update_o}, 32'd0);
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        @(negedge sys_clk_96M);
        model_reset();
        check("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data_o}, 32'h00);
        check("rst_cfg_update", {31'd0, cfg_update_o}, 32'd0);
        check("rst_pkt_err", {31'd0, pkt_err_o}, 32'd0);
        check_outputs("rst");
        sys_rst = 1'b0;
    endtask

    initial begin
        int k;
        bit saw_tx;
        rx_data_i     = 8'h00;
        rx_valid_i    = 1'b0;
        tx_ready_i    = 1'b1;
        frame_start_i = 1'b0;
        sys_rst       = 1'b1;
        repeat (3) @(negedge sys_clk_96M);
        pulse_reset();
        frame_pulse();

        // Reference packet 1280x720 -> 2560x1440; applied only at frame start.
        send_pkt(1, 1280, 720, 2560, 1440, 0, 1'b0, 1'b0);
        frame_pulse();

        // Checksum off by one, illegal dimensions, wrong command.
        send_pkt(1, 800, 600, 1024, 768, 1, 1'b0, 1'b0);
        frame_pulse();
        send_pkt(1, 640, 480, 2561, 1440, 0, 1'b0, 1'b0);
        send_pkt(1, 640, 0, 1024, 768, 0, 1'b0, 1'b0);
        send_pkt(2, 640, 480, 1024, 768, 0, 1'b0, 1'b0);
        send_pkt(1, 4096, 480, 1024, 768, 0, 1'b0, 1'b0);
        frame_pulse();

        // Exact maxima, repeated header byte and a broken header.
        send_byte(8'h33);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("hdr_mismatch_no_err", {31'd0, pkt_err_o}, 32'd0);
        send_byte(8'hA5);
        send_pkt(1, 2560, 1440, 1, 1, 0, 1'b0, 1'b1);
        frame_pulse();

        // Inter-byte gap timeout.
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        k = 0;
        saw_tx = 1'b0;
        while ((pkt_err_o !== 1'b1) && (k < T_CYC + 20)) begin
            @(negedge sys_clk_96M);
            k++;
            if (tx_valid_o !== 1'b0) saw_tx = 1'b1;
        end
        check("timeout_cycles", k, T_CYC);
        check("timeout_no_tx", {31'd0, saw_tx}, 32'd0);
        @(negedge sys_clk_96M);
        check("timeout_pulse_end", {31'd0, pkt_err_o}, 32'd0);
        send_pkt(1, 1024, 576, 2048, 1152, 0, 1'b0, 1'b0);
        frame_pulse();

        // Last good packet wins; frame start during EVAL commits the older one.
        send_pkt(1, 320, 240, 640, 480, 0, 1'b0, 1'b0);
        send_pkt(1, 352, 288, 704, 576, 0, 1'b0, 1'b0);
        frame_pulse();
        send_pkt(1, 100, 200, 300, 400, 0, 1'b0, 1'b0);
        send_pkt(1, 500, 600, 700, 800, 0, 1'b1, 1'b0);
        frame_pulse();

        // Back-pressure on the reply, then reset while the reply is held.
        tx_ready_i = 1'b0;
        send_pkt(1, 720, 480, 1440, 960, 0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk_96M);
            check("bp_tx_valid", {31'd0, tx_valid_o}, 32'd1);
            check("bp_tx_data", {24'd0, tx_data_o}, 32'h06);
        end
        pulse_reset();
        tx_ready_i = 1'b1;

        // Reset mid-payload discards the packet and any pending setting.
        send_pkt(1, 111, 222, 333, 444, 0, 1'b0, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        pulse_reset();
        frame_pulse();
        send_pkt(1, 1280, 720, 1920, 1080, 0, 1'b0, 1'b0);
        frame_pulse();

        // Randomized packets with junk bytes, gaps and optional frame starts.
        for (int it = 0; it < 24; it++) begin
            int kind;
            int cmd;
            int delta;
            int r;
            int nj;
            int lim;
            logic [7:0] jb;
            int d [4];
            d[0] = $urandom_range(1, MAX_W);
            d[1] = $urandom_range(1, MAX_H);
            d[2] = $urandom_range(1, MAX_W);
            d[3] = $urandom_range(1, MAX_H);
            cmd = 1;
            delta = 0;
            kind = $urandom_range(0, 4);
            r = $urandom_range(0, 3);
            lim = ((r % 2) == 0) ? MAX_W : MAX_H;
            case (kind)
                1: delta = $urandom_range(1, 255);
                2: begin
                    cmd = $urandom_range(0, 255);
                    if (cmd == 1) cmd = 0;
                end
                3: d[r] = 0;
                4: d[r] = $urandom_range(lim + 1, 65535);
                default: cmd = 1;
            endcase
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'h5A) jb = 8'h00;
                send_byte(jb);
            end
            send_pkt(cmd, d[0], d[1], d[2], d[3], delta, ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 1) == 1) frame_pulse();
        end
        frame_pulse();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
